// File: rtl/arb_pkg.sv
// Shared types and constants for the 5-requester round-robin port arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ   = 5;
  localparam int unsigned SEL_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (idx == SEL_WIDTH'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/mux5_port_arbiter_rr_pick5.sv
// Combinational round-robin pick: first set request searching upward from last+1, wrapping 4->0.
module rr_pick5
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [SEL_WIDTH-1:0] i_last,
  output logic [SEL_WIDTH-1:0] o_idx,
  output logic                 o_found
);

  logic [SEL_WIDTH-1:0] cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    cand    = '0;
    for (int d = 1; d <= NUM_REQ; d++) begin
      cand = SEL_WIDTH'((int'(i_last) + d) % NUM_REQ);
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux5_port_arbiter.sv
// Round-robin arbiter for one shared port: grant, valid/ready issue, completion wait, done pulse.
// Optional watchdog abort enabled by defining ARB_WATCHDOG_EN.
module mux5_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_arstn,
  input  logic [NUM_REQ-1:0]   i_req,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [SEL_WIDTH-1:0] o_sel,
  output logic                 o_port_valid,
  input  logic                 i_port_ready,
  input  logic                 i_port_done,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_err,
  output arb_state_e           o_dbg_state
);

  // Port handshake: an issue transfers on an edge where o_port_valid and i_port_ready are
  // both high; i_port_done is only honoured in WAIT or together with that transfer.

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic                 complete;
  logic                 timeout;

  rr_pick5 u_pick (
    .i_req   (i_req),
    .i_last  (last_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = '0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_port_ready) begin
          valid_d = 1'b0;
          if (i_port_done) complete = 1'b1;
          else             state_d  = WAIT;
        end
      end
      WAIT: begin
        if (i_port_done) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A real completion and a watchdog abort retire the transaction identically.
    if (complete || timeout) begin
      done_d  = gnt_q;
      gnt_d   = '0;
      valid_d = 1'b0;
      last_d  = sel_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_WIDTH'(NUM_REQ - 1);
      valid_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  // Counter sits at zero in IDLE so it reads zero on the first ISSUE cycle.
  always_comb begin
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    timeout = (state_q != IDLE) && !complete &&
              (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    err_d   = timeout;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_WIDTH[0]};
  assign timeout    = 1'b0;
  assign o_err      = 1'b0;
`endif

  assign o_gnt        = gnt_q;
  assign o_sel        = sel_q;
  assign o_port_valid = valid_q;
  assign o_done       = done_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mux5_port_arbiter.sv
// Randomized transaction-level bench for mux5_port_arbiter with a round-robin reference model.
// Define ARB_WATCHDOG_EN to also exercise the watchdog abort.
module tb_mux5_port_arbiter;
  import arb_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic       i_clk = 1'b0;
  logic       i_arstn;
  logic [4:0] i_req;
  logic [4:0] o_gnt;
  logic [2:0] o_sel;
  logic       o_port_valid;
  logic       i_port_ready;
  logic       i_port_done;
  logic [4:0] o_done;
  logic       o_err;
  arb_state_e o_dbg_state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] req_m;
  int         last_m;
  logic [4:0] exp_q[$];

  mux5_port_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_arstn      (i_arstn),
    .i_req        (i_req),
    .o_gnt        (o_gnt),
    .o_sel        (o_sel),
    .o_port_valid (o_port_valid),
    .i_port_ready (i_port_ready),
    .i_port_done  (i_port_done),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Reference: the winner is the requester whose distance after the last grant is smallest.
  function automatic int exp_winner(input logic [4:0] r, input int last);
    int best = -1;
    int best_d = 99;
    for (int k = 0; k < 5; k++) begin
      if (r[k]) begin
        int d = (k - last - 1 + 10) % 5;
        if (d < best_d) begin
          best_d = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  // driver: one full transaction, starting at a negedge with the DUT idle
  task automatic run_txn(input int rdly, input int ddly, input bit together, input bit drop_mid);
    int         w;
    logic [4:0] oh;
    logic [4:0] exp_done;
    i_req = req_m;
    w = exp_winner(req_m, last_m);
    oh = 5'b00001 << w;
    exp_q.push_back(oh);
    tick();
    check_eq("gnt", 32'(o_gnt), 32'(oh));
    check_eq("sel", 32'(o_sel), 32'(w));
    check_eq("valid_up", 32'(o_port_valid), 32'd1);
    check_eq("done_quiet", 32'(o_done), 32'd0);
    req_m = req_m | 5'($urandom_range(0, 31));
    i_req = req_m;
    for (int i = 0; i < rdly; i++) begin
      i_port_ready = 1'b0;
      i_port_done  = 1'($urandom_range(0, 1));
      tick();
      check_eq("valid_hold", 32'(o_port_valid), 32'd1);
      check_eq("gnt_hold_issue", 32'(o_gnt), 32'(oh));
      check_eq("done_ignored", 32'(o_done), 32'd0);
    end
    i_port_ready = 1'b1;
    i_port_done  = together;
    tick();
    i_port_ready = 1'b0;
    i_port_done  = 1'b0;
    if (!together) begin
      check_eq("valid_drop", 32'(o_port_valid), 32'd0);
      check_eq("gnt_hold_wait", 32'(o_gnt), 32'(oh));
      check_eq("done_wait", 32'(o_done), 32'd0);
      if (drop_mid) begin
        req_m[w] = 1'b0;
        i_req = req_m;
      end
      for (int i = 0; i < ddly; i++) begin
        i_port_ready = 1'($urandom_range(0, 1));
        tick();
        check_eq("gnt_wait", 32'(o_gnt), 32'(oh));
        check_eq("done_wait", 32'(o_done), 32'd0);
      end
      i_port_ready = 1'b0;
      i_port_done  = 1'b1;
      tick();
      i_port_done  = 1'b0;
    end
    exp_done = exp_q.pop_front();
    check_eq("done_pulse", 32'(o_done), 32'(exp_done));
    check_eq("gnt_clear", 32'(o_gnt), 32'd0);
    check_eq("valid_idle", 32'(o_port_valid), 32'd0);
    check_eq("err_quiet", 32'(o_err), 32'd0);
    check_eq("sel_retain", 32'(o_sel), 32'(w));
    req_m[w] = 1'b0;
    last_m = w;
    i_req = req_m;
  endtask

  task automatic idle_cycles(input int n);
    req_m = '0;
    i_req = '0;
    for (int i = 0; i < n; i++) begin
      i_port_done = 1'($urandom_range(0, 1));
      tick();
      check_eq("idle_gnt", 32'(o_gnt), 32'd0);
      check_eq("idle_valid", 32'(o_port_valid), 32'd0);
      check_eq("idle_done", 32'(o_done), 32'd0);
    end
    i_port_done = 1'b0;
  endtask

  initial begin
    i_arstn = 1'b0;
    i_req = '0;
    i_port_ready = 1'b0;
    i_port_done = 1'b0;
    req_m = '0;
    last_m = 4;
    tick();
    tick();
    check_eq("rst_gnt", 32'(o_gnt), 32'd0);
    check_eq("rst_sel", 32'(o_sel), 32'd0);
    check_eq("rst_valid", 32'(o_port_valid), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    check_eq("rst_state", 32'(o_dbg_state), 32'(IDLE));
    i_arstn = 1'b1;
    tick();

    // rotation with all requests held and immediate ready+done
    for (int i = 0; i < 6; i++) begin
      req_m = 5'b11111;
      run_txn(0, 0, 1'b1, 1'b0);
      check_eq("rotation", 32'(last_m), 32'(i % 5));
    end
    idle_cycles(2);

    // single request, ready after 2 cycles, done after 3 more
    req_m = 5'b00100;
    run_txn(2, 3, 1'b0, 1'b0);
    idle_cycles(1);

    // wrap priority: last=3 then 00101 -> 0, then 2
    req_m = 5'b01000;
    run_txn(0, 1, 1'b0, 1'b0);
    req_m = 5'b00101;
    run_txn(1, 0, 1'b0, 1'b0);
    run_txn(0, 0, 1'b0, 1'b1);
    idle_cycles(1);

    // reset during WAIT abandons the transaction
    req_m = 5'b01000;
    i_req = req_m;
    tick();
    check_eq("pre_rst_gnt", 32'(o_gnt), 32'b01000);
    i_port_ready = 1'b1;
    tick();
    i_port_ready = 1'b0;
    tick();
    #2 i_arstn = 1'b0;
    #1;
    check_eq("async_gnt", 32'(o_gnt), 32'd0);
    check_eq("async_valid", 32'(o_port_valid), 32'd0);
    check_eq("async_sel", 32'(o_sel), 32'd0);
    check_eq("async_state", 32'(o_dbg_state), 32'(IDLE));
    i_port_done = 1'b1;
    tick();
    check_eq("rst_no_done", 32'(o_done), 32'd0);
    i_port_done = 1'b0;
    i_arstn = 1'b1;
    last_m = 4;
    req_m = 5'b01001;
    run_txn(0, 0, 1'b1, 1'b0);
    idle_cycles(1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 5) == 0) idle_cycles($urandom_range(1, 3));
      req_m = req_m | 5'($urandom_range(0, 31));
      if (req_m == '0) req_m[$urandom_range(0, 4)] = 1'b1;
      run_txn($urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

`ifdef ARB_WATCHDOG_EN
    // watchdog: ready but no done, abort lands TB_TIMEOUT cycles after ISSUE entry
    begin
      int         w;
      int         seen;
      logic [4:0] oh;
      idle_cycles(1);
      req_m = 5'b10010;
      w = exp_winner(req_m, last_m);
      oh = 5'b00001 << w;
      i_req = req_m;
      tick();
      check_eq("wd_gnt", 32'(o_gnt), 32'(oh));
      i_port_ready = 1'b1;
      seen = -1;
      for (int c = 1; c <= TB_TIMEOUT + 2 && seen < 0; c++) begin
        tick();
        i_port_ready = 1'b0;
        if (o_done != '0) begin
          seen = c;
          check_eq("wd_done", 32'(o_done), 32'(oh));
          check_eq("wd_err", 32'(o_err), 32'd1);
          check_eq("wd_valid", 32'(o_port_valid), 32'd0);
        end
      end
      check_eq("wd_latency", 32'(seen), 32'(TB_TIMEOUT));
      req_m[w] = 1'b0;
      last_m = w;
      i_req = req_m;
      tick();
      check_eq("wd_err_pulse", 32'(o_err), 32'd0);
      check_eq("wd_next_gnt", 32'(o_gnt), 32'(5'b00001 << exp_winner(req_m, last_m)));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
